// File: rtl/digit_serial_addsub.sv
// digit_serial_addsub
//   Multi-cycle two's-complement adder/subtractor. Operands are consumed
//   DIGIT bits per clock, LSB digit first, so a long add needs only a
//   DIGIT-wide carry chain. Results are registered and presented with a
//   one-cycle done pulse. Signed overflow is flagged, and the sum can
//   optionally be clamped when overflow occurs.
//
// Parameters
//   WIDTH     operand/result width (>= 2)
//   DIGIT     bits processed per clock (WIDTH must be a multiple of DIGIT)
//   SATURATE  1: clamp sum on signed overflow, 0: wrap
//
// Ports
//   clk       system clock, rising edge
//   rst_n     asynchronous active-low reset
//   start     request, sampled only while not busy
//   sub       0: x + y + cin, 1: x - y (cin ignored)
//   x, y      operands, two's complement
//   cin       carry-in, add mode only
//   busy      operation in progress
//   done      one-cycle pulse, sum/cout/overflow valid
//   sum       result (wrapped or saturated)
//   cout      raw carry out of the MSB (sub: 1 = no borrow)
//   overflow  signed overflow (carry into MSB xor carry out of MSB)
//
// state | meaning
// IDLE  | waiting for start
// RUN   | one digit slice added per clock
// DONE  | result valid for one cycle, new start accepted here

module digit_serial_addsub #(
    parameter int WIDTH    = 13,
    parameter int DIGIT    = 1,
    parameter int SATURATE = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    generate
        if ((WIDTH % DIGIT) != 0 || WIDTH < 2 || DIGIT < 1) begin : g_param_check
            $error("digit_serial_addsub: WIDTH must be >= 2 and a multiple of DIGIT");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] xr, yr;
    logic [WIDTH-1:0] xr_next, yr_next;
    logic             carry;
    logic             x_msb;
    logic [CW-1:0]    cnt;
    logic             last;
    logic             accept;
    logic [DIGIT-1:0] slice_sum;
    logic             slice_cout;
    logic             slice_cmsb;
    logic             ovf_next;
    logic [WIDTH-1:0] sat_val;

    assign last   = (cnt == CW'(N - 1));
    assign accept = start && (state_q != RUN);
    assign busy   = (state_q == RUN);
    assign done   = (state_q == DONE);

    // Ripple through one digit; the carry entering the top bit of the slice
    // is kept because on the final digit that top bit is the word's MSB.
    always_comb begin
        logic c;
        slice_sum  = '0;
        slice_cmsb = 1'b0;
        c          = carry;
        for (int i = 0; i < DIGIT; i++) begin
            if (i == DIGIT - 1) slice_cmsb = c;
            slice_sum[i] = xr[i] ^ yr[i] ^ c;
            c = (xr[i] & yr[i]) | (c & (xr[i] ^ yr[i]));
        end
        slice_cout = c;
    end

    // The result digits are shifted in at the top of xr as its operand digits
    // are consumed from the bottom, so after N steps xr holds the full sum.
    generate
        if (N == 1) begin : g_single
            assign xr_next = slice_sum;
            assign yr_next = yr;
        end else begin : g_multi
            assign xr_next = {slice_sum, xr[WIDTH-1:DIGIT]};
            assign yr_next = {{DIGIT{1'b0}}, yr[WIDTH-1:DIGIT]};
        end
    endgenerate

    assign ovf_next = slice_cmsb ^ slice_cout;
    // On overflow both operands share x's sign, so x's sign picks the rail.
    assign sat_val  = x_msb ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (last)  state_d = DONE;
            DONE:    state_d = start ? RUN : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            xr       <= '0;
            yr       <= '0;
            carry    <= 1'b0;
            x_msb    <= 1'b0;
            cnt      <= '0;
            sum      <= '0;
            cout     <= 1'b0;
            overflow <= 1'b0;
        end else if (accept) begin
            xr    <= x;
            yr    <= sub ? ~y : y;
            carry <= sub ? 1'b1 : cin;
            x_msb <= x[WIDTH-1];
            cnt   <= '0;
        end else if (state_q == RUN) begin
            xr    <= xr_next;
            yr    <= yr_next;
            carry <= slice_cout;
            cnt   <= cnt + CW'(1);
            if (last) begin
                sum      <= ((SATURATE != 0) && ovf_next) ? sat_val : xr_next;
                cout     <= slice_cout;
                overflow <= ovf_next;
            end
        end
    end

endmodule

// File: tb/tb_digit_serial_addsub.sv
module tb_digit_serial_addsub;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, start_c;
    logic        sub;
    logic [12:0] x, y;
    logic        cin;

    logic        a_busy, a_done, a_cout, a_ovf;
    logic [12:0] a_sum;
    logic        b_busy, b_done, b_cout, b_ovf;
    logic [12:0] b_sum;
    logic        c_busy, c_done, c_cout, c_ovf;
    logic [12:0] c_sum;

    int total = 0;
    int bad   = 0;
    logic [12:0] a_hold = '0;

    always #5 clk = ~clk;

    // a: serial, wrap   b: serial, saturate   c: single-cycle, wrap
    digit_serial_addsub #(.WIDTH(13), .DIGIT(1), .SATURATE(0)) u_a (
        .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .x(x), .y(y), .cin(cin),
        .busy(a_busy), .done(a_done), .sum(a_sum), .cout(a_cout), .overflow(a_ovf));

    digit_serial_addsub #(.WIDTH(13), .DIGIT(1), .SATURATE(1)) u_b (
        .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .x(x), .y(y), .cin(cin),
        .busy(b_busy), .done(b_done), .sum(b_sum), .cout(b_cout), .overflow(b_ovf));

    digit_serial_addsub #(.WIDTH(13), .DIGIT(13), .SATURATE(0)) u_c (
        .clk(clk), .rst_n(rst_n), .start(start_c), .sub(sub), .x(x), .y(y), .cin(cin),
        .busy(c_busy), .done(c_done), .sum(c_sum), .cout(c_cout), .overflow(c_ovf));

    task automatic chk(input string tag, input logic [12:0] obs, input logic [12:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Launch one operation (called #1 after a rising edge, or during DONE for
    // back-to-back) and follow it for 13 edges, checking handshake and results.
    task automatic run(input string tag, input logic s, input logic [12:0] xv, input logic [12:0] yv,
                       input logic ci, input logic use_c, input logic mid,
                       input logic [12:0] ea, input logic [12:0] eb, input logic ec, input logic eo);
        sub     = s;
        x       = xv;
        y       = yv;
        cin     = ci;
        start   = 1'b1;
        start_c = use_c;
        @(posedge clk);
        #1;
        start   = 1'b0;
        start_c = 1'b0;
        chk({tag, " a.busy@k"}, a_busy, 1'b1);
        chk({tag, " a.done@k"}, a_done, 1'b0);
        if (use_c) chk({tag, " c.busy@k"}, c_busy, 1'b1);
        for (int cyc = 1; cyc <= 13; cyc++) begin
            @(posedge clk);
            #1;
            if (cyc < 13) begin
                chk($sformatf("%s a.busy@k+%0d", tag, cyc), a_busy, 1'b1);
                chk($sformatf("%s a.done@k+%0d", tag, cyc), a_done, 1'b0);
            end else begin
                chk({tag, " a.busy@k+13"}, a_busy, 1'b0);
                chk({tag, " a.done@k+13"}, a_done, 1'b1);
                chk({tag, " a.sum"}, a_sum, ea);
                chk({tag, " a.cout"}, a_cout, ec);
                chk({tag, " a.ovf"}, a_ovf, eo);
                chk({tag, " b.done"}, b_done, 1'b1);
                chk({tag, " b.sum"}, b_sum, eb);
                chk({tag, " b.cout"}, b_cout, ec);
                chk({tag, " b.ovf"}, b_ovf, eo);
            end
            if (cyc == 6) chk({tag, " a.sum held in RUN"}, a_sum, a_hold);
            if (use_c && cyc == 1) begin
                chk({tag, " c.done@k+1"}, c_done, 1'b1);
                chk({tag, " c.busy@k+1"}, c_busy, 1'b0);
                chk({tag, " c.sum"}, c_sum, ea);
                chk({tag, " c.cout"}, c_cout, ec);
                chk({tag, " c.ovf"}, c_ovf, eo);
            end
            if (use_c && cyc == 2) chk({tag, " c.done@k+2"}, c_done, 1'b0);
            if (mid && cyc == 2) begin
                start = 1'b1;
                sub   = ~s;
                x     = ~xv;
                y     = ~yv;
                cin   = ~ci;
            end
            if (mid && cyc == 3) start = 1'b0;
        end
        a_hold = ea;
    endtask

    task automatic idle1();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n   = 1'b0;
        start   = 1'b0;
        start_c = 1'b0;
        sub     = 1'b0;
        x       = '0;
        y       = '0;
        cin     = 1'b0;
        #2;
        chk("reset a.busy", a_busy, 1'b0);
        chk("reset a.done", a_done, 1'b0);
        chk("reset a.sum", a_sum, 13'h0000);
        chk("reset a.cout", a_cout, 1'b0);
        chk("reset a.ovf", a_ovf, 1'b0);
        chk("reset c.sum", c_sum, 13'h0000);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        idle1();

        // positive overflow: wrap vs clamp
        run("add 0FFF+1", 1'b0, 13'h0FFF, 13'h0001, 1'b0, 1'b1, 1'b0, 13'h1000, 13'h0FFF, 1'b0, 1'b1);
        idle1();
        // negative overflow (-4096 + -1)
        run("add 1000+1FFF", 1'b0, 13'h1000, 13'h1FFF, 1'b0, 1'b1, 1'b0, 13'h0FFF, 13'h1000, 1'b1, 1'b1);
        idle1();
        run("add 1FFF+1", 1'b0, 13'h1FFF, 13'h0001, 1'b0, 1'b1, 1'b0, 13'h0000, 13'h0000, 1'b1, 1'b0);
        idle1();
        // cin must be ignored in subtract mode
        run("sub 5-7", 1'b1, 13'h0005, 13'h0007, 1'b1, 1'b1, 1'b0, 13'h1FFE, 13'h1FFE, 1'b0, 1'b0);
        idle1();
        run("sub 1000-1", 1'b1, 13'h1000, 13'h0001, 1'b0, 1'b1, 1'b0, 13'h0FFF, 13'h1000, 1'b1, 1'b1);
        idle1();
        // carry-in used, with a start pulse and operand change mid-run
        run("add 3+4+1 mid", 1'b0, 13'h0003, 13'h0004, 1'b1, 1'b0, 1'b1, 13'h0008, 13'h0008, 1'b0, 1'b0);
        // accepted during DONE: back-to-back
        run("b2b 0FFF+1", 1'b0, 13'h0FFF, 13'h0001, 1'b0, 1'b1, 1'b0, 13'h1000, 13'h0FFF, 1'b0, 1'b1);
        idle1();

        // reset in the middle of a run
        sub   = 1'b0;
        x     = 13'h0123;
        y     = 13'h0456;
        cin   = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int cyc = 1; cyc <= 6; cyc++) begin
            @(posedge clk);
            #1;
        end
        rst_n = 1'b0;
        #1;
        chk("midrst a.busy", a_busy, 1'b0);
        chk("midrst a.done", a_done, 1'b0);
        chk("midrst a.sum", a_sum, 13'h0000);
        chk("midrst a.cout", a_cout, 1'b0);
        chk("midrst a.ovf", a_ovf, 1'b0);
        chk("midrst b.sum", b_sum, 13'h0000);
        for (int cyc = 0; cyc < 10; cyc++) begin
            @(posedge clk);
            #1;
            chk($sformatf("midrst no done %0d", cyc), a_done, 1'b0);
        end
        @(negedge clk);
        rst_n  = 1'b1;
        a_hold = '0;
        idle1();
        run("post-reset 2+3", 1'b0, 13'h0002, 13'h0003, 1'b0, 1'b1, 1'b0, 13'h0005, 13'h0005, 1'b0, 1'b0);
        idle1();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
